// File: rtl/mem_arbiter16_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter16_if
// Bus bundle for the single-port memory arbiter.
//
// Signal groups:
//   cpu_*   pipeline16 CPU port (active-low strobes, wait, read data)
//   p0_*    peripheral master 0 (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   p1_*    peripheral master 1 (same shape as p0)
//   mem_*   shared memory port (address, write data, active-low strobes,
//           read data returned one cycle after the read strobe)
//
// Modports:
//   slave   the arbiter side (receives requests, drives grants and memory)
//   master  the requester/memory side (drives requests and memory read data)
// ---------------------------------------------------------------------------
interface mem_arbiter16_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
);
    logic [ADDR_BITS-1:0] cpu_addr;
    logic [DATA_BITS-1:0] cpu_wdata;
    logic                 cpu_OEb;
    logic                 cpu_WRb;
    logic [DATA_BITS-1:0] cpu_rdata;
    logic                 cpu_wait;

    logic                 p0_req;
    logic                 p0_we;
    logic [ADDR_BITS-1:0] p0_addr;
    logic [DATA_BITS-1:0] p0_wdata;
    logic                 p0_gnt;
    logic                 p0_rvalid;
    logic [DATA_BITS-1:0] p0_rdata;

    logic                 p1_req;
    logic                 p1_we;
    logic [ADDR_BITS-1:0] p1_addr;
    logic [DATA_BITS-1:0] p1_wdata;
    logic                 p1_gnt;
    logic                 p1_rvalid;
    logic [DATA_BITS-1:0] p1_rdata;

    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic                 mem_OEb;
    logic                 mem_WRb;
    logic [DATA_BITS-1:0] mem_rdata;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_OEb, cpu_WRb,
        output cpu_rdata, cpu_wait,
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_addr, mem_wdata, mem_OEb, mem_WRb,
        input  mem_rdata
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_OEb, cpu_WRb,
        input  cpu_rdata, cpu_wait,
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_addr, mem_wdata, mem_OEb, mem_WRb,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter16.sv
// ---------------------------------------------------------------------------
// mem_arbiter16
// Shares one 16-bit memory port between the pipeline16 CPU and two
// peripheral masters (P0, P1). One access per cycle, chosen combinationally.
// The CPU is held off with cpu_wait whenever a peripheral owns the bus, and
// read data comes back one cycle later with a per-peripheral rvalid pulse.
//
// Ports:
//   CLK   system clock, all state on the rising edge
//   RSTb  asynchronous active-low reset
//   bus   mem_arbiter16_if.slave: CPU port, P0/P1 ports, memory port
//
// Parameters:
//   ADDR_BITS     memory address width
//   DATA_BITS     memory data width
//   STARVE_LIMIT  consecutive CPU wins tolerated while a peripheral waits
//
// Build option:
//   MEMARB_STARVE_GUARD_EN  when defined, a starvation counter lets a waiting
//                           peripheral through after STARVE_LIMIT CPU wins.
//                           When undefined the CPU has strict priority and no
//                           counter exists.
// ---------------------------------------------------------------------------
module mem_arbiter16 #(
    parameter int ADDR_BITS    = 16,
    parameter int DATA_BITS    = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           CLK,
    input  logic           RSTb,
    mem_arbiter16_if.slave bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_P0   = 2'd2,
        OWN_P1   = 2'd3
    } owner_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_check
        $error("mem_arbiter16: STARVE_LIMIT must be in 1..255");
    end

    owner_t               owner;
    owner_t               rr_pick;
    owner_t               rd_owner;
    logic                 rr_last;      // 0 = P0 served last, 1 = P1 served last
    logic                 cpu_act;
    logic                 any_req;
    logic                 guard_trip;
    logic [ADDR_BITS-1:0] addr_hold;
    logic [DATA_BITS-1:0] wdata_hold;

    assign cpu_act = !bus.cpu_OEb || !bus.cpu_WRb;
    assign any_req = bus.p0_req || bus.p1_req;

`ifdef MEMARB_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT8 = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;

    assign guard_trip = (starve_cnt == LIMIT8);

    // Counts CPU wins that left a peripheral waiting; any peripheral grant or
    // a cycle with nobody waiting starts the count over.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            starve_cnt <= '0;
        end else if (owner == OWN_P0 || owner == OWN_P1 || !any_req) begin
            starve_cnt <= '0;
        end else if (owner == OWN_CPU && starve_cnt != LIMIT8) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    assign guard_trip = 1'b0;
`endif

    // Owner selection. Forcing NONE during reset keeps strobes, grants and
    // the memory address at their reset values while RSTb is low.
    always_comb begin
        rr_pick = OWN_P1;
        if (bus.p0_req && bus.p1_req) begin
            rr_pick = rr_last ? OWN_P0 : OWN_P1;
        end else if (bus.p0_req) begin
            rr_pick = OWN_P0;
        end

        owner = OWN_NONE;
        if (!RSTb) begin
            owner = OWN_NONE;
        end else if (cpu_act && !guard_trip) begin
            owner = OWN_CPU;
        end else if (any_req) begin
            owner = rr_pick;
        end else if (cpu_act) begin
            owner = OWN_CPU;
        end
    end

    // Memory port mux. A CPU access with both strobes low is a write only.
    always_comb begin
        bus.mem_addr  = addr_hold;
        bus.mem_wdata = wdata_hold;
        bus.mem_OEb   = 1'b1;
        bus.mem_WRb   = 1'b1;
        case (owner)
            OWN_CPU: begin
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
                if (!bus.cpu_WRb) bus.mem_WRb = 1'b0;
                else              bus.mem_OEb = 1'b0;
            end
            OWN_P0: begin
                bus.mem_addr  = bus.p0_addr;
                bus.mem_wdata = bus.p0_wdata;
                if (bus.p0_we) bus.mem_WRb = 1'b0;
                else           bus.mem_OEb = 1'b0;
            end
            OWN_P1: begin
                bus.mem_addr  = bus.p1_addr;
                bus.mem_wdata = bus.p1_wdata;
                if (bus.p1_we) bus.mem_WRb = 1'b0;
                else           bus.mem_OEb = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign bus.p0_gnt    = (owner == OWN_P0);
    assign bus.p1_gnt    = (owner == OWN_P1);
    assign bus.cpu_wait  = RSTb && cpu_act && (owner != OWN_CPU);

    assign bus.p0_rvalid = (rd_owner == OWN_P0);
    assign bus.p1_rvalid = (rd_owner == OWN_P1);
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.p0_rdata  = bus.mem_rdata;
    assign bus.p1_rdata  = bus.mem_rdata;

    // Round-robin memory, idle-hold of the address/data lines, and the read
    // owner that turns into a one-cycle rvalid on the following cycle.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            rr_last    <= 1'b1;
            addr_hold  <= '0;
            wdata_hold <= '0;
            rd_owner   <= OWN_NONE;
        end else begin
            if (owner == OWN_P0) begin
                rr_last <= 1'b0;
            end else if (owner == OWN_P1) begin
                rr_last <= 1'b1;
            end
            addr_hold  <= bus.mem_addr;
            wdata_hold <= bus.mem_wdata;
            rd_owner   <= bus.mem_OEb ? OWN_NONE : owner;
        end
    end

endmodule

// File: tb/tb_mem_arbiter16.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter16
// Self-checking bench for mem_arbiter16. A behavioural model (last-served
// peripheral, starvation count, pending read returns and a sparse memory
// image) predicts every output; the bench also acts as the memory, returning
// data from that image one cycle after each read strobe.
// Build option MEMARB_STARVE_GUARD_EN selects the guarded expectations.
// ---------------------------------------------------------------------------
module tb_mem_arbiter16;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LIMIT = 8;
`ifdef MEMARB_STARVE_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic CLK;
    logic RSTb;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            last_p;
    int            starve;
    bit            pend0, pend1, pendc;
    logic [DW-1:0] rd_val;
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    logic [DW-1:0] mem_model [int];

    // Model predictions for the current cycle (owner: 0 none, 1 cpu, 2 p0, 3 p1)
    int            e_own;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_oeb, e_wrb, e_wait, e_g0, e_g1;

    mem_arbiter16_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

    mem_arbiter16 #(
        .ADDR_BITS(AW),
        .DATA_BITS(DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .CLK (CLK),
        .RSTb(RSTb),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] simulation time limit reached");
    end

    function automatic logic [DW-1:0] mem_peek(input logic [AW-1:0] a);
        if (mem_model.exists(int'(a))) return mem_model[int'(a)];
        return a ^ 16'hC3A5;
    endfunction

    task automatic model_reset();
        last_p = 1;
        starve = 0;
        pend0  = 1'b0;
        pend1  = 1'b0;
        pendc  = 1'b0;
        hold_a = '0;
        hold_d = '0;
    endtask

    // Predict this cycle's owner and memory port from the arbitration rules.
    task automatic model_eval();
        bit cact, anyp, trip;
        int pick;
        cact = !bus.cpu_OEb || !bus.cpu_WRb;
        anyp = bus.p0_req || bus.p1_req;
        if (bus.p0_req && bus.p1_req) pick = (last_p == 1) ? 0 : 1;
        else                          pick = bus.p0_req ? 0 : 1;
        trip = GUARD_ON && (starve >= LIMIT);
        if (!RSTb)               e_own = 0;
        else if (cact && !trip)  e_own = 1;
        else if (anyp)           e_own = 2 + pick;
        else if (cact)           e_own = 1;
        else                     e_own = 0;
        e_addr  = hold_a;
        e_wdata = hold_d;
        e_oeb   = 1'b1;
        e_wrb   = 1'b1;
        case (e_own)
            1: begin
                e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
                if (!bus.cpu_WRb) e_wrb = 1'b0; else e_oeb = 1'b0;
            end
            2: begin
                e_addr = bus.p0_addr; e_wdata = bus.p0_wdata;
                if (bus.p0_we) e_wrb = 1'b0; else e_oeb = 1'b0;
            end
            3: begin
                e_addr = bus.p1_addr; e_wdata = bus.p1_wdata;
                if (bus.p1_we) e_wrb = 1'b0; else e_oeb = 1'b0;
            end
            default: begin
            end
        endcase
        e_wait = RSTb && cact && (e_own != 1);
        e_g0   = (e_own == 2);
        e_g1   = (e_own == 3);
    endtask

    // Advance the model across a rising edge.
    task automatic model_commit();
        bit anyp;
        anyp = bus.p0_req || bus.p1_req;
        if (!RSTb) begin
            model_reset();
            rd_val = '0;
        end else begin
            pendc = (e_own == 1) && !e_oeb;
            pend0 = (e_own == 2) && !e_oeb;
            pend1 = (e_own == 3) && !e_oeb;
            if (!e_oeb) rd_val = mem_peek(e_addr);
            else        rd_val = 16'($urandom);
            if (!e_wrb) mem_model[int'(e_addr)] = e_wdata;
            if (e_own != 0) begin
                hold_a = e_addr;
                hold_d = e_wdata;
            end
            if (e_own >= 2) begin
                last_p = e_own - 2;
                starve = 0;
            end else if (!anyp) begin
                starve = 0;
            end else if (e_own == 1 && starve < LIMIT) begin
                starve++;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_commit();
        #1;
        bus.mem_rdata = rd_val;
    endtask

    task automatic test_reset();
        RSTb          = 1'b0;
        model_reset();
        rd_val        = '0;
        bus.mem_rdata = '0;
        bus.cpu_addr  = 16'h0010;
        bus.cpu_wdata = 16'h0000;
        bus.cpu_OEb   = 1'b0;
        bus.cpu_WRb   = 1'b1;
        bus.p0_req    = 1'b1;
        bus.p0_we     = 1'b0;
        bus.p0_addr   = 16'h0100;
        bus.p0_wdata  = 16'h0000;
        bus.p1_req    = 1'b0;
        bus.p1_we     = 1'b0;
        bus.p1_addr   = 16'h0000;
        bus.p1_wdata  = 16'h0000;
        @(negedge CLK);
        n_checks++; if (bus.mem_OEb !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_mem_OEb: got %b expected 1", bus.mem_OEb); end
        n_checks++; if (bus.mem_WRb !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_mem_WRb: got %b expected 1", bus.mem_WRb); end
        n_checks++; if (bus.p0_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_p0_gnt: got %b expected 0", bus.p0_gnt); end
        n_checks++; if (bus.cpu_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cpu_wait: got %b expected 0", bus.cpu_wait); end
        n_checks++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
        n_checks++; if (bus.p0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_p0_rvalid: got %b expected 0", bus.p0_rvalid); end
        @(posedge CLK);
        #1;
        RSTb = 1'b1;
        @(negedge CLK);
        model_eval();
        n_checks++; if (bus.mem_OEb !== 1'b0) begin n_fail++; $display("[TB] FAIL release_mem_OEb: got %b expected 0", bus.mem_OEb); end
        n_checks++; if (bus.mem_addr !== 16'h0010) begin n_fail++; $display("[TB] FAIL release_mem_addr: got %h expected 0010", bus.mem_addr); end
        n_checks++; if (bus.cpu_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL release_cpu_wait: got %b expected 0", bus.cpu_wait); end
        n_checks++; if (bus.p0_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL release_p0_gnt: got %b expected 0", bus.p0_gnt); end
        tick();
        bus.p0_req  = 1'b0;
        bus.cpu_OEb = 1'b1;
    endtask

    task automatic test_round_robin();
        bus.p0_req   = 1'b1;
        bus.p0_we    = 1'b0;
        bus.p0_addr  = 16'h3000;
        bus.p1_req   = 1'b1;
        bus.p1_we    = 1'b1;
        bus.p1_addr  = 16'h2000;
        bus.p1_wdata = 16'h00AA;
        for (int i = 0; i < 6; i++) begin
            logic exp0;
            exp0 = (i % 2 == 0);
            @(negedge CLK);
            model_eval();
            n_checks++; if (bus.p0_gnt !== exp0) begin n_fail++; $display("[TB] FAIL rr_p0_gnt step %0d: got %b expected %b", i, bus.p0_gnt, exp0); end
            n_checks++; if (bus.p1_gnt !== !exp0) begin n_fail++; $display("[TB] FAIL rr_p1_gnt step %0d: got %b expected %b", i, bus.p1_gnt, !exp0); end
            if (!exp0) begin
                n_checks++; if (bus.mem_WRb !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_p1_WRb step %0d: got %b expected 0", i, bus.mem_WRb); end
                n_checks++; if (bus.mem_wdata !== 16'h00AA) begin n_fail++; $display("[TB] FAIL rr_p1_wdata step %0d: got %h expected 00aa", i, bus.mem_wdata); end
                n_checks++; if (bus.mem_addr !== 16'h2000) begin n_fail++; $display("[TB] FAIL rr_p1_addr step %0d: got %h expected 2000", i, bus.mem_addr); end
            end
            tick();
        end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        @(negedge CLK);
        model_eval();
        tick();
    endtask

    task automatic test_p0_read();
        mem_model[16'h1234] = 16'hBEEF;
        bus.p0_req  = 1'b1;
        bus.p0_we   = 1'b0;
        bus.p0_addr = 16'h1234;
        @(negedge CLK);
        model_eval();
        n_checks++; if (bus.p0_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL p0rd_gnt: got %b expected 1", bus.p0_gnt); end
        n_checks++; if (bus.mem_OEb !== 1'b0) begin n_fail++; $display("[TB] FAIL p0rd_OEb: got %b expected 0", bus.mem_OEb); end
        n_checks++; if (bus.mem_addr !== 16'h1234) begin n_fail++; $display("[TB] FAIL p0rd_addr: got %h expected 1234", bus.mem_addr); end
        tick();
        bus.p0_req = 1'b0;
        @(negedge CLK);
        model_eval();
        n_checks++; if (bus.p0_rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL p0rd_rvalid: got %b expected 1", bus.p0_rvalid); end
        n_checks++; if (bus.p0_rdata !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL p0rd_rdata: got %h expected beef", bus.p0_rdata); end
        n_checks++; if (bus.p1_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL p0rd_p1_rvalid: got %b expected 0", bus.p1_rvalid); end
        tick();
        @(negedge CLK);
        model_eval();
        n_checks++; if (bus.p0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL p0rd_rvalid_drop: got %b expected 0", bus.p0_rvalid); end
        tick();
    endtask

    task automatic test_contention();
        bus.cpu_OEb  = 1'b0;
        bus.cpu_WRb  = 1'b1;
        bus.p1_req   = 1'b1;
        bus.p1_we    = 1'b1;
        bus.p1_addr  = 16'h2100;
        bus.p1_wdata = 16'h5555;
        for (int i = 0; i < 27; i++) begin
            logic exp1;
            exp1 = GUARD_ON && (i % (LIMIT + 1) == LIMIT);
            bus.cpu_addr = 16'($urandom_range(0, 255));
            @(negedge CLK);
            model_eval();
            n_checks++; if (bus.p1_gnt !== exp1) begin n_fail++; $display("[TB] FAIL cont_p1_gnt step %0d: got %b expected %b", i, bus.p1_gnt, exp1); end
            n_checks++; if (bus.cpu_wait !== exp1) begin n_fail++; $display("[TB] FAIL cont_cpu_wait step %0d: got %b expected %b", i, bus.cpu_wait, exp1); end
            tick();
        end
        bus.cpu_OEb = 1'b1;
        @(negedge CLK);
        model_eval();
        n_checks++; if (bus.p1_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL cont_idle_p1_gnt: got %b expected 1", bus.p1_gnt); end
        n_checks++; if (bus.cpu_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_idle_cpu_wait: got %b expected 0", bus.cpu_wait); end
        tick();
        bus.p1_req = 1'b0;
    endtask

    task automatic test_both_strobes();
        bus.cpu_OEb   = 1'b0;
        bus.cpu_WRb   = 1'b0;
        bus.cpu_addr  = 16'h0400;
        bus.cpu_wdata = 16'h1357;
        @(negedge CLK);
        model_eval();
        n_checks++; if (bus.mem_OEb !== 1'b1) begin n_fail++; $display("[TB] FAIL both_OEb: got %b expected 1", bus.mem_OEb); end
        n_checks++; if (bus.mem_WRb !== 1'b0) begin n_fail++; $display("[TB] FAIL both_WRb: got %b expected 0", bus.mem_WRb); end
        n_checks++; if (bus.mem_wdata !== 16'h1357) begin n_fail++; $display("[TB] FAIL both_wdata: got %h expected 1357", bus.mem_wdata); end
        n_checks++; if (bus.cpu_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL both_cpu_wait: got %b expected 0", bus.cpu_wait); end
        tick();
        bus.cpu_OEb = 1'b1;
        bus.cpu_WRb = 1'b1;
        @(negedge CLK);
        model_eval();
        n_checks++; if (bus.mem_addr !== 16'h0400) begin n_fail++; $display("[TB] FAIL idle_hold_addr: got %h expected 0400", bus.mem_addr); end
        n_checks++; if (bus.mem_WRb !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_WRb: got %b expected 1", bus.mem_WRb); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        bus.p0_req  = 1'b1;
        bus.p0_we   = 1'b0;
        bus.p0_addr = 16'h0055;
        @(negedge CLK);
        model_eval();
        n_checks++; if (bus.p0_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_gnt: got %b expected 1", bus.p0_gnt); end
        #1;
        RSTb = 1'b0;
        model_reset();
        bus.p0_req = 1'b0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        n_checks++; if (bus.p0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_rvalid_in_reset: got %b expected 0", bus.p0_rvalid); end
        @(posedge CLK);
        #1;
        RSTb = 1'b1;
        @(negedge CLK);
        model_eval();
        n_checks++; if (bus.p0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_rvalid_after: got %b expected 0", bus.p0_rvalid); end
        tick();
    endtask

    task automatic test_random();
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            case ($urandom_range(0, 4))
                2:       begin bus.cpu_OEb = 1'b0; bus.cpu_WRb = 1'b1; end
                3:       begin bus.cpu_OEb = 1'b1; bus.cpu_WRb = 1'b0; end
                4:       begin bus.cpu_OEb = 1'b0; bus.cpu_WRb = 1'b0; end
                default: begin bus.cpu_OEb = 1'b1; bus.cpu_WRb = 1'b1; end
            endcase
            bus.cpu_addr  = 16'($urandom_range(0, 31));
            bus.cpu_wdata = 16'($urandom);
            @(negedge CLK);
            model_eval();
            n_checks++; if (bus.mem_OEb !== e_oeb) begin n_fail++; $display("[TB] FAIL rand_mem_OEb cyc %0d: got %b expected %b", cyc, bus.mem_OEb, e_oeb); end
            n_checks++; if (bus.mem_WRb !== e_wrb) begin n_fail++; $display("[TB] FAIL rand_mem_WRb cyc %0d: got %b expected %b", cyc, bus.mem_WRb, e_wrb); end
            n_checks++; if (bus.mem_addr !== e_addr) begin n_fail++; $display("[TB] FAIL rand_mem_addr cyc %0d: got %h expected %h", cyc, bus.mem_addr, e_addr); end
            n_checks++; if (bus.mem_wdata !== e_wdata) begin n_fail++; $display("[TB] FAIL rand_mem_wdata cyc %0d: got %h expected %h", cyc, bus.mem_wdata, e_wdata); end
            n_checks++; if (bus.p0_gnt !== e_g0) begin n_fail++; $display("[TB] FAIL rand_p0_gnt cyc %0d: got %b expected %b", cyc, bus.p0_gnt, e_g0); end
            n_checks++; if (bus.p1_gnt !== e_g1) begin n_fail++; $display("[TB] FAIL rand_p1_gnt cyc %0d: got %b expected %b", cyc, bus.p1_gnt, e_g1); end
            n_checks++; if (bus.cpu_wait !== e_wait) begin n_fail++; $display("[TB] FAIL rand_cpu_wait cyc %0d: got %b expected %b", cyc, bus.cpu_wait, e_wait); end
            n_checks++; if (bus.p0_rvalid !== pend0) begin n_fail++; $display("[TB] FAIL rand_p0_rvalid cyc %0d: got %b expected %b", cyc, bus.p0_rvalid, pend0); end
            n_checks++; if (bus.p1_rvalid !== pend1) begin n_fail++; $display("[TB] FAIL rand_p1_rvalid cyc %0d: got %b expected %b", cyc, bus.p1_rvalid, pend1); end
            if (pend0) begin
                n_checks++; if (bus.p0_rdata !== rd_val) begin n_fail++; $display("[TB] FAIL rand_p0_rdata cyc %0d: got %h expected %h", cyc, bus.p0_rdata, rd_val); end
            end
            if (pend1) begin
                n_checks++; if (bus.p1_rdata !== rd_val) begin n_fail++; $display("[TB] FAIL rand_p1_rdata cyc %0d: got %h expected %h", cyc, bus.p1_rdata, rd_val); end
            end
            if (pendc) begin
                n_checks++; if (bus.cpu_rdata !== rd_val) begin n_fail++; $display("[TB] FAIL rand_cpu_rdata cyc %0d: got %h expected %h", cyc, bus.cpu_rdata, rd_val); end
            end
            tick();
            // Requesters hold their request until granted, occasionally withdrawing.
            if (bus.p0_req && !e_g0) begin
                if ($urandom_range(0, 15) == 0) bus.p0_req = 1'b0;
            end else begin
                bus.p0_req   = 1'($urandom_range(0, 1));
                bus.p0_we    = 1'($urandom_range(0, 1));
                bus.p0_addr  = 16'($urandom_range(0, 31));
                bus.p0_wdata = 16'($urandom);
            end
            if (bus.p1_req && !e_g1) begin
                if ($urandom_range(0, 15) == 0) bus.p1_req = 1'b0;
            end else begin
                bus.p1_req   = 1'($urandom_range(0, 1));
                bus.p1_we    = 1'($urandom_range(0, 1));
                bus.p1_addr  = 16'($urandom_range(0, 31));
                bus.p1_wdata = 16'($urandom);
            end
        end
        bus.p0_req  = 1'b0;
        bus.p1_req  = 1'b0;
        bus.cpu_OEb = 1'b1;
        bus.cpu_WRb = 1'b1;
    endtask

    initial begin : main
        $display("[TB] mem_arbiter16 bench start, guard=%0d", GUARD_ON);
        test_reset();
        test_round_robin();
        test_p0_read();
        test_contention();
        test_both_strobes();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter16.md
# mem_arbiter16

Single-port memory arbiter that shares the 16-bit memory bus between the pipeline16 CPU port and two peripheral bus masters (P0, P1, e.g. DMA and video fetch). It sits between the pipeline's `mem_OEb`/`mem_WRb`/address/data signals and the memory. It grants one access per cycle. It stalls the CPU with `cpu_wait` when a peripheral owns the bus, and steers read data back to the winning requester.

## Interface
- `ADDR_BITS`, 16, memory address width
- `DATA_BITS`, 16, memory data width
- `STARVE_LIMIT`, 8, consecutive CPU wins tolerated while a peripheral waits (guard build only; 1..255)

Ports:
- `CLK`  in  1  system clock, all state on rising edge
- `RSTb`  in  1  reset, asynchronous, active-low
- `cpu_addr`  in  ADDR_BITS  CPU access address
- `cpu_wdata`  in  DATA_BITS  CPU store data
- `cpu_OEb`  in  1  CPU read request, active-low
- `cpu_WRb`  in  1  CPU write request, active-low
- `cpu_rdata`  out  DATA_BITS  read data to pipeline
- `cpu_wait`  out  1  high = CPU access not performed this cycle, pipeline holds
- `p0_req`, `p1_req`  in  1  peripheral access request
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read
- `p0_addr`, `p1_addr`  in  ADDR_BITS  peripheral address
- `p0_wdata`, `p1_wdata`  in  DATA_BITS  peripheral write data
- `p0_gnt`, `p1_gnt`  out  1  access performed this cycle
- `p0_rvalid`, `p1_rvalid`  out  1  `pN_rdata` valid (cycle after granted read)
- `p0_rdata`, `p1_rdata`  out  DATA_BITS  read data
- `mem_addr`  out  ADDR_BITS  memory address
- `mem_wdata`  out  DATA_BITS  memory write data
- `mem_OEb`, `mem_WRb`  out  1  memory strobes, active-low
- `mem_rdata`  in  DATA_BITS  memory read data, valid one cycle after read strobe

## Operation
- Owner is chosen combinationally each cycle from: CPU, P0, P1, or NONE.
- `cpu_act` = `!cpu_OEb || !cpu_WRb`. If both strobes are low, the access is a write and the read is ignored.
- Priority:
  - If `cpu_act` and the guard has not tripped, the owner is CPU.
  - Otherwise, if any `pN_req` is set, the owner is the round-robin peripheral winner.
  - Otherwise, if `cpu_act`, the owner is CPU.
  - Otherwise the owner is NONE.
- Round-robin:
  - `rr_last` register holds the last-served peripheral.
  - If both P0 and P1 request, the winner is the one not equal to `rr_last`.
  - `rr_last` updates on every peripheral grant.
- The owner's address, data and strobes drive the `mem_*` signals. A peripheral read drives `mem_OEb`=0; a peripheral write drives `mem_WRb`=0. NONE drives both strobes high, and `mem_addr`/`mem_wdata` hold their last values.
- `pN_gnt` = owner is PN. The requester keeps `req`/`we`/`addr`/`wdata` stable until it samples `gnt`=1 at a rising edge. It may drop `req` before grant (withdraw, no effect).
- `cpu_wait` = `cpu_act && owner != CPU`.
- Read return:
  - `rd_owner` register captures the owner on every read cycle.
  - `pN_rvalid` is a registered flag, high for exactly one cycle after a PN read grant.
  - `pN_rdata` and `cpu_rdata` = `mem_rdata`.
- Back-to-back grants to the same peripheral on consecutive cycles are legal (full throughput).

## Timing
- Grant and `cpu_wait` are combinational: zero-cycle arbitration, one memory access per cycle.
- Read latency is 1 cycle: strobe at cycle N, data and `rvalid` at cycle N+1.
- Reset values (asynchronous, and forced while `RSTb`=0):
  - `mem_OEb`=`mem_WRb`=1, `mem_addr`=`mem_wdata`=0
  - all `gnt`=0, all `rvalid`=0, `cpu_wait`=0
  - `rr_last`=P1 (so P0 is preferred first)
  - `starve_cnt`=0, `rd_owner`=NONE
- Reset mid-read: a pending `rvalid` is cleared and never asserted.
- Simultaneous CPU + P0 + P1 requests (guard not tripped): CPU wins, and both peripherals see `gnt`=0.

## Configuration
- `MEMARB_STARVE_GUARD_EN` defined:
  - An 8-bit `starve_cnt` increments on each cycle where CPU wins while any `pN_req`=1. It saturates at `STARVE_LIMIT`.
  - When `starve_cnt == STARVE_LIMIT`, the guard trips: the next cycle grants the round-robin peripheral and stalls the CPU.
  - `starve_cnt` clears on any peripheral grant, or in any cycle with no peripheral request.
- Not defined:
  - The CPU has strict priority. Peripherals are granted only in cycles where `cpu_act`=0.
  - No counter is synthesized.

## Test plan
- **Reset:** hold `RSTb`=0 with `p0_req`=1, `cpu_OEb`=0 -> `mem_OEb`=`mem_WRb`=1, `p0_gnt`=0, `cpu_wait`=0. After release, first cycle gives the CPU read at `cpu_addr`=0x0010 with `mem_OEb`=0.
- **P0 read, CPU idle:** `p0_req`=1, `p0_we`=0, `p0_addr`=0x1234, `mem_rdata`=0xBEEF next cycle -> `p0_gnt`=1 in cycle N, `p0_rvalid`=1 and `p0_rdata`=0xBEEF in N+1 only.
- **Round-robin:** P0 and P1 request continuously, CPU idle -> grants alternate P0, P1, P0, P1 starting with P0. A P1 write of 0x00AA to 0x2000 shows `mem_WRb`=0, `mem_wdata`=0x00AA.
- **Contention:** CPU reads every cycle while P1 requests.
  - With guard and `STARVE_LIMIT`=8: 8 CPU grants, then a P1 grant with `cpu_wait`=1 for that one cycle, repeating.
  - Without guard: P1 is never granted until the CPU goes idle.
- **Both CPU strobes low:** `cpu_OEb`=`cpu_WRb`=0 -> memory sees write only (`mem_OEb`=1, `mem_WRb`=0).
- **Reset mid-read:** P0 read granted, then `RSTb` asserted before the next edge -> `p0_rvalid` stays 0.
